// File: rtl/la_pkg.sv
// Shared definitions for the logic analyzer UART blocks (uart_rx / uart_tx).
package la_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_e;

  // 100 MHz system clock, 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 868;
endpackage

// File: rtl/uart_rx_if.sv
// Serial input and byte-delivery signals between the UART receiver and its consumer.
interface uart_rx_if;
  logic       rx_i;
  logic       data_received_o;
  logic [7:0] data_o;
  logic       rx_active_o;
  logic       frame_err_o;

  modport slave (
    input  rx_i,
    output data_received_o, data_o, rx_active_o, frame_err_o
  );

  modport master (
    output rx_i,
    input  data_received_o, data_o, rx_active_o, frame_err_o
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, good-byte strobe, framing-error strobe and break hold-off.
module uart_rx
  import la_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input logic      clk_i,
  input logic      rst_n_i,
  uart_rx_if.slave uart
);
  if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic           rx_s;
  uart_rx_state_e state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [7:0]     data_q, data_d;
  logic           drx_q, drx_d;
  logic           ferr_q, ferr_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .d     (uart.rx_i),
    .q     (rx_s)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      drx_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      drx_q   <= drx_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    drx_d   = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      // Start bit must still be low at its midpoint, otherwise it was a glitch
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shreg_q;
            drx_d   = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // A line held low after a bad stop bit must not be taken as new start bits
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign uart.data_received_o = drx_q;
  assign uart.data_o          = data_q;
  assign uart.frame_err_o     = ferr_q;
  assign uart.rx_active_o     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx, checked against a byte-level reference model.
module tb_uart_rx;
  localparam int C = 16;
  // sync (2) + IDLE detect (1) + half start bit + 9 full bit periods
  localparam int STROBE_LAT = 3 + C / 2 + 9 * C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  uart_rx_if ifc ();

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .uart    (ifc.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] rcv_q[$];
  int         rcv_cyc_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int wide_cnt = 0;
  int act_rise_cyc = -1;
  int last_start_cyc = 0;
  logic prev_drx = 1'b0;
  logic prev_act = 1'b0;

  always @(negedge clk) begin
    if (ifc.data_received_o === 1'b1) begin
      rcv_q.push_back(ifc.data_o);
      rcv_cyc_q.push_back(cyc);
    end
    if (ifc.frame_err_o === 1'b1) ferr_cnt++;
    if (ifc.data_received_o === 1'b1 && ifc.frame_err_o === 1'b1) both_cnt++;
    if (ifc.data_received_o === 1'b1 && prev_drx) wide_cnt++;
    if (ifc.rx_active_o === 1'b1 && !prev_act) act_rise_cyc = cyc;
    prev_drx = (ifc.data_received_o === 1'b1);
    prev_act = (ifc.rx_active_o === 1'b1);
  end

  task automatic idle(input int n);
    ifc.rx_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic lvl, input int n);
    ifc.rx_i = lvl;
    repeat (n) @(negedge clk);
  endtask

  // jit alternates bit lengths per-1 / per+1 starting with the start bit
  task automatic send_frame(input logic [7:0] b, input logic stop, input int per, input bit jit);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    last_start_cyc = cyc;
    for (int n = 0; n < 10; n++)
      drive_bit(bits[n], per + (jit ? ((n % 2 == 0) ? -1 : 1) : 0));
    if (stop) begin
      exp_q.push_back(b);
      last_good = b;
    end
  endtask

  task automatic clear_obs();
    rcv_q.delete();
    rcv_cyc_q.delete();
    exp_q.delete();
    ferr_cnt = 0;
    both_cnt = 0;
    wide_cnt = 0;
  endtask

  task automatic test_reset();
    ifc.rx_i = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    total_cnt++; if (ifc.data_received_o !== 1'b0) $display("FAIL reset_drx: got %b want 0", ifc.data_received_o); else pass_cnt++;
    total_cnt++; if (ifc.data_o !== 8'h00) $display("FAIL reset_data: got %h want 00", ifc.data_o); else pass_cnt++;
    total_cnt++; if (ifc.rx_active_o !== 1'b0) $display("FAIL reset_active: got %b want 0", ifc.rx_active_o); else pass_cnt++;
    total_cnt++; if (ifc.frame_err_o !== 1'b0) $display("FAIL reset_ferr: got %b want 0", ifc.frame_err_o); else pass_cnt++;
    rst_n = 1'b1;
    idle(10);
    total_cnt++; if (ifc.rx_active_o !== 1'b0) $display("FAIL idle_active: got %b want 0", ifc.rx_active_o); else pass_cnt++;
  endtask

  task automatic test_single_frame();
    int mid_active;
    clear_obs();
    act_rise_cyc = -1;
    send_frame(8'hA5, 1'b1, C, 1'b0);
    mid_active = -1;
    idle(30);
    total_cnt++; if (rcv_q.size() != 1) $display("FAIL single_count: got %0d want 1", rcv_q.size()); else pass_cnt++;
    if (rcv_q.size() == 1) begin
      total_cnt++; if (rcv_q[0] !== 8'hA5) $display("FAIL single_data: got %h want a5", rcv_q[0]); else pass_cnt++;
      total_cnt++; if (rcv_cyc_q[0] - last_start_cyc != STROBE_LAT)
        $display("FAIL single_latency: got %0d want %0d", rcv_cyc_q[0] - last_start_cyc, STROBE_LAT); else pass_cnt++;
    end
    total_cnt++; if (act_rise_cyc - last_start_cyc != 3)
      $display("FAIL active_rise: got %0d want 3", act_rise_cyc - last_start_cyc); else pass_cnt++;
    total_cnt++; if (ferr_cnt != 0) $display("FAIL single_ferr: got %0d want 0", ferr_cnt); else pass_cnt++;
    total_cnt++; if (ifc.rx_active_o !== 1'b0) $display("FAIL single_active_end: got %b want 0", ifc.rx_active_o); else pass_cnt++;
    total_cnt++; if (ifc.data_o !== 8'hA5) $display("FAIL single_hold: got %h want a5", ifc.data_o); else pass_cnt++;
    total_cnt++; if (wide_cnt != 0) $display("FAIL single_width: got %0d wide strobes want 0", wide_cnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    clear_obs();
    send_frame(8'h81, 1'b1, C, 1'b0);
    send_frame(8'h3C, 1'b1, C, 1'b0);
    idle(30);
    total_cnt++; if (rcv_q.size() != 2) $display("FAIL b2b_count: got %0d want 2", rcv_q.size()); else pass_cnt++;
    for (int i = 0; i < 2 && i < rcv_q.size(); i++) begin
      total_cnt++; if (rcv_q[i] !== exp_q[i]) $display("FAIL b2b_data%0d: got %h want %h", i, rcv_q[i], exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (ifc.data_o !== 8'h3C) $display("FAIL b2b_hold: got %h want 3c", ifc.data_o); else pass_cnt++;
    total_cnt++; if (wide_cnt != 0) $display("FAIL b2b_width: got %0d wide strobes want 0", wide_cnt); else pass_cnt++;
  endtask

  task automatic test_random();
    clear_obs();
    for (int i = 0; i < 8; i++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1, C, 1'b0);
      idle($urandom_range(0, 12));
    end
    idle(30);
    total_cnt++; if (rcv_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", rcv_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      total_cnt++; if (rcv_q[i] !== exp_q[i]) $display("FAIL rand_data%0d: got %h want %h", i, rcv_q[i], exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (ifc.data_o !== last_good) $display("FAIL rand_hold: got %h want %h", ifc.data_o, last_good); else pass_cnt++;
  endtask

  task automatic test_glitch();
    clear_obs();
    drive_bit(1'b0, 5);
    idle(40);
    total_cnt++; if (rcv_q.size() != 0) $display("FAIL glitch_strobe: got %0d strobes want 0", rcv_q.size()); else pass_cnt++;
    total_cnt++; if (ferr_cnt != 0) $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt); else pass_cnt++;
    total_cnt++; if (ifc.data_o !== last_good) $display("FAIL glitch_hold: got %h want %h", ifc.data_o, last_good); else pass_cnt++;
    total_cnt++; if (ifc.rx_active_o !== 1'b0) $display("FAIL glitch_active: got %b want 0", ifc.rx_active_o); else pass_cnt++;
  endtask

  task automatic test_framing_break();
    int low_cnt;
    int n;
    logic [7:0] prev_good;
    clear_obs();
    prev_good = last_good;
    send_frame(8'h5A, 1'b0, C, 1'b0);
    low_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifc.rx_active_o !== 1'b1) low_cnt++;
    end
    total_cnt++; if (ferr_cnt != 1) $display("FAIL ferr_count: got %0d want 1", ferr_cnt); else pass_cnt++;
    total_cnt++; if (rcv_q.size() != 0) $display("FAIL ferr_strobe: got %0d strobes want 0", rcv_q.size()); else pass_cnt++;
    total_cnt++; if (ifc.data_o !== prev_good) $display("FAIL ferr_hold: got %h want %h", ifc.data_o, prev_good); else pass_cnt++;
    total_cnt++; if (low_cnt != 0) $display("FAIL break_active: got %0d inactive cycles want 0", low_cnt); else pass_cnt++;
    ifc.rx_i = 1'b1;
    n = 0;
    for (int i = 0; i < 10 && ifc.rx_active_o !== 1'b0; i++) begin
      @(negedge clk);
      n++;
    end
    total_cnt++; if (n != 3) $display("FAIL break_release: got %0d cycles want 3", n); else pass_cnt++;
    idle(5);
    send_frame(8'h11, 1'b1, C, 1'b0);
    idle(30);
    total_cnt++; if (rcv_q.size() != 1 || rcv_q[0] !== 8'h11)
      $display("FAIL after_break: got %0d strobes data %h want 1 strobe data 11", rcv_q.size(), ifc.data_o); else pass_cnt++;
    total_cnt++; if (both_cnt != 0) $display("FAIL strobe_overlap: got %0d want 0", both_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits;
    clear_obs();
    bits = {1'b1, 8'($urandom_range(1, 255)), 1'b0};
    for (int n = 0; n < 5; n++) drive_bit(bits[n], C);
    drive_bit(bits[5], C / 2);
    rst_n = 1'b0;
    #1;
    total_cnt++; if (ifc.rx_active_o !== 1'b0) $display("FAIL midrst_active: got %b want 0", ifc.rx_active_o); else pass_cnt++;
    total_cnt++; if (ifc.data_o !== 8'h00) $display("FAIL midrst_data: got %h want 00", ifc.data_o); else pass_cnt++;
    total_cnt++; if (ifc.data_received_o !== 1'b0 || ifc.frame_err_o !== 1'b0)
      $display("FAIL midrst_strobes: got %b%b want 00", ifc.data_received_o, ifc.frame_err_o); else pass_cnt++;
    last_good = 8'h00;
    ifc.rx_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    total_cnt++; if (rcv_q.size() != 0) $display("FAIL midrst_partial: got %0d strobes want 0", rcv_q.size()); else pass_cnt++;
    send_frame(8'hC3, 1'b1, C, 1'b0);
    idle(30);
    total_cnt++; if (rcv_q.size() != 1 || ifc.data_o !== 8'hC3)
      $display("FAIL midrst_recover: got %0d strobes data %h want 1 strobe data c3", rcv_q.size(), ifc.data_o); else pass_cnt++;
  endtask

  task automatic test_baud_skew();
    clear_obs();
    send_frame(8'h96, 1'b1, C, 1'b1);
    send_frame(8'h69, 1'b1, C, 1'b1);
    idle(30);
    total_cnt++; if (rcv_q.size() != 2) $display("FAIL skew_count: got %0d want 2", rcv_q.size()); else pass_cnt++;
    for (int i = 0; i < 2 && i < rcv_q.size(); i++) begin
      total_cnt++; if (rcv_q[i] !== exp_q[i]) $display("FAIL skew_data%0d: got %h want %h", i, rcv_q[i], exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (ferr_cnt != 0) $display("FAIL skew_ferr: got %0d want 0", ferr_cnt); else pass_cnt++;
  endtask

  initial begin
    ifc.rx_i = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_random();
    test_glitch();
    test_framing_break();
    test_reset_mid_frame();
    test_baud_skew();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the logic analyzer command path. It oversamples the asynchronous serial input, recovers 8N1 frames (LSB first) and presents each good byte to `cmd_int` as a one-cycle `data_received` strobe with `data`. It also drives the `rx_active` status that `cmd_int` uses for `cmd_busy`, and flags framing errors.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 868 (100 MHz / 115200 baud): clock cycles per serial bit. Must be 4 or more. Elaboration fails on a smaller value.

Ports:
- `clk_i`  in  1  system clock; the block's only clock.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `rx_i`  in  1  serial line, asynchronous to `clk_i`, idle high.
- `data_received_o`  out  1  one-cycle strobe: `data_o` holds a newly received good byte. Feeds `cmd_int.data_received_i`.
- `data_o`  out  8  last good byte received. Feeds `cmd_int.data_i`.
- `rx_active_o`  out  1  high while a frame (or a line break) is in progress. Feeds `cmd_int.rx_active_i`.
- `frame_err_o`  out  1  one-cycle strobe: the stop bit was sampled low.

## Operation

- **Synchronizer:** `rx_i` passes through a 2-flop synchronizer, reset value 1. All logic below uses the synchronized value `rx_s`.
- **Counters:**
  - Bit-period counter `cnt`, width `$clog2(CLKS_PER_BIT)`.
  - Bit index `idx`, 3 bits.
  - Shift register `shreg`, 8 bits.
- **State machine:**
  - **IDLE:**
    - `rx_s == 0`: go to START, `cnt <= 0`.
  - **START:**
    - `cnt` counts up to `CLKS_PER_BIT/2 - 1` (integer division).
    - At that count, `rx_s == 0`: go to DATA, `cnt <= 0`, `idx <= 0`.
    - At that count, `rx_s == 1`: glitch; go to IDLE with no strobe.
  - **DATA:**
    - `cnt` counts up to `CLKS_PER_BIT - 1`.
    - At that count: `shreg <= {rx_s, shreg[7:1]}` (LSB first), `cnt <= 0`, `idx <= idx + 1`.
    - After the sample with `idx == 7`: go to STOP.
  - **STOP:**
    - `cnt` counts up to `CLKS_PER_BIT - 1`, then samples `rx_s`.
    - `rx_s == 1`: `data_o <= shreg`, pulse `data_received_o`, go to IDLE.
    - `rx_s == 0`: pulse `frame_err_o`, leave `data_o` unchanged, go to BREAK.
  - **BREAK:**
    - Wait until `rx_s == 1`, then go to IDLE. This prevents a held-low line from retriggering frames.
- **Outputs:**
  - `rx_active_o = (state != IDLE)`, decoded from the registered state.
  - `data_received_o` and `frame_err_o` are registered and never high together.
- **Reset:**
  - Assertion at any time, including mid-frame, returns the block to IDLE and clears `cnt`, `idx` and `shreg`.
  - All outputs take their reset values.
  - A partial frame is discarded silently.

## Timing

- **Output reset values:** `data_received_o = 0`, `data_o = 8'h00`, `rx_active_o = 0`, `frame_err_o = 0`. Synchronizer flops reset to 1.
- **Input latency:** 2 cycles from a `rx_i` edge to `rx_s`.
- **Frame latency:** let T0 be the first cycle in which `rx_s == 0` is seen in IDLE.
  - `rx_active_o` rises at T0+1.
  - The start-bit check falls at the middle of the start bit.
  - Data bit k is sampled one full bit period after the previous sample point (k = 0..7).
  - The stop bit is sampled 9 full bit periods after the start-bit check.
  - The strobe and IDLE (`rx_active_o` low) are visible the cycle after the stop sample.
- **Back-to-back frames:** a new start bit that begins right after the stop-sample cycle is accepted. There is no dead time beyond the return to IDLE.
- **Baud tolerance:** it is at least ±3% mismatch between transmitter and `CLKS_PER_BIT` with `CLKS_PER_BIT >= 16`.
- **Strobe width:** exactly 1 cycle. `data_o` stays stable until the next good frame.

## Structure

- **Shared package:** `la_pkg` holds `uart_rx_state_e` (IDLE, START, DATA, STOP, BREAK) and the default-baud constant. The matching `uart_tx` uses the same package.
- **Sub-module:** `sync_2ff`, a reusable 1-bit synchronizer with a parameterized reset value. It is instantiated once here.
- **Integration:** `uart_rx` connects point-to-point to `cmd_int`. No glue logic is needed.

## Test plan

All scenarios run with `CLKS_PER_BIT = 16`.

- **Single frame:** send 8'hA5 with a good stop bit -> exactly one `data_received_o` pulse, `data_o = 8'hA5`, `frame_err_o` stays 0, and `rx_active_o` is high for the frame then low.
- **Back-to-back command:** send 8'h81 then 8'h3C with zero idle between frames -> two pulses in order, `data_o` = 8'h81 then 8'h3C. `cmd_int` downstream issues a write of 8'h3C to address 7'h01.
- **Glitch reject:** drive `rx_i` low for 5 cycles (shorter than a half bit of 8) -> START returns to IDLE, no strobe, `data_o` unchanged.
- **Framing error and break:** send 8'h5A with the stop bit low, then hold the line low for 200 cycles -> one `frame_err_o` pulse, no `data_received_o`, `data_o` keeps its previous value, and `rx_active_o` stays high until the line goes high. A following 8'h11 frame is received correctly.
- **Reset mid-frame:** assert `rst_n_i` during data bit 4 -> all outputs go to reset values at once. After release, 8'hC3 is received correctly.
- **Baud skew:** send 8'h96 and 8'h69 with bit periods of 15 and 17 cycles -> both bytes received correctly, no framing error.
